// File: rtl/counter_updown_mod.sv
// Configurable-width up/down counter with programmable ceiling, wrap/saturate
// mode, terminal count, cascade enable and sticky overflow.
module counter_updown_mod #(
  parameter int              WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
  parameter bit              SATURATE = 1'b0
) (
  input  logic             C,
  input  logic             CLR_N,
  input  logic             SCLR,
  input  logic             CE,
  input  logic             UP_DN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             CEO,
  output logic             OVF
);

  logic [WIDTH-1:0] q_nxt;
  logic             ovf_nxt;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (Q == MAX_VAL);
  assign at_zero = (Q == '0);

  // Boundaries are detected by compare, not by carry, so non-power-of-two
  // ceilings wrap at MAX_VAL rather than at 2**WIDTH.
  always_comb begin
    q_nxt   = Q;
    ovf_nxt = OVF;
    if (SCLR) begin
      q_nxt   = '0;
      ovf_nxt = 1'b0;
    end else if (LOAD) begin
      q_nxt = (D > MAX_VAL) ? MAX_VAL : D;
    end else if (CE) begin
      if (UP_DN) begin
        if (at_max) begin
          ovf_nxt = 1'b1;
          q_nxt   = SATURATE ? MAX_VAL : '0;
        end else begin
          q_nxt = Q + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          ovf_nxt = 1'b1;
          q_nxt   = SATURATE ? '0 : MAX_VAL;
        end else begin
          q_nxt = Q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      Q   <= '0;
      OVF <= 1'b0;
    end else begin
      Q   <= q_nxt;
      OVF <= ovf_nxt;
    end
  end

  assign TC  = UP_DN ? at_max : at_zero;
  assign CEO = CE & TC;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench: wrap/saturate instances, two-stage decade cascade, and a
// default-width instance for natural 2**WIDTH wrap.
module tb_counter_updown_mod;

  logic C, rst_n;
  int checks, failures;

  // instance a: W4 M9 wrap
  logic sclr_a, ce_a, up_a, load_a;
  logic [3:0] d_a, q_a;
  logic tc_a, ceo_a, ovf_a;
  // instance b: W4 M9 saturate
  logic sclr_b, ce_b, up_b, load_b;
  logic [3:0] d_b, q_b;
  logic tc_b, ceo_b, ovf_b;
  // cascade lo/hi
  logic sclr_c, ce_c;
  logic [3:0] d_c, q_lo, q_hi;
  logic tc_lo, ceo_lo, ovf_lo, tc_hi, ceo_hi, ovf_hi;
  // instance e: default W8
  logic ce_e, up_e;
  logic [7:0] d_e, q_e;
  logic tc_e, ceo_e, ovf_e;

  counter_updown_mod #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) u_a (
    .C(C), .CLR_N(rst_n), .SCLR(sclr_a), .CE(ce_a), .UP_DN(up_a), .LOAD(load_a),
    .D(d_a), .Q(q_a), .TC(tc_a), .CEO(ceo_a), .OVF(ovf_a));

  counter_updown_mod #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1)) u_b (
    .C(C), .CLR_N(rst_n), .SCLR(sclr_b), .CE(ce_b), .UP_DN(up_b), .LOAD(load_b),
    .D(d_b), .Q(q_b), .TC(tc_b), .CEO(ceo_b), .OVF(ovf_b));

  counter_updown_mod #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) u_lo (
    .C(C), .CLR_N(rst_n), .SCLR(sclr_c), .CE(ce_c), .UP_DN(1'b1), .LOAD(1'b0),
    .D(d_c), .Q(q_lo), .TC(tc_lo), .CEO(ceo_lo), .OVF(ovf_lo));

  counter_updown_mod #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) u_hi (
    .C(C), .CLR_N(rst_n), .SCLR(sclr_c), .CE(ceo_lo), .UP_DN(1'b1), .LOAD(1'b0),
    .D(d_c), .Q(q_hi), .TC(tc_hi), .CEO(ceo_hi), .OVF(ovf_hi));

  counter_updown_mod u_e (
    .C(C), .CLR_N(rst_n), .SCLR(1'b0), .CE(ce_e), .UP_DN(up_e), .LOAD(1'b0),
    .D(d_e), .Q(q_e), .TC(tc_e), .CEO(ceo_e), .OVF(ovf_e));

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge C);
    #1;
  endtask

  int up_seq[12]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int up_ovf[12]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
  int dn_seq[5]   = '{9, 8, 7, 6, 5};
  int sat_ovf[3]  = '{0, 1, 1};

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    sclr_a = 0; ce_a = 0; up_a = 1; load_a = 0; d_a = 0;
    sclr_b = 0; ce_b = 0; up_b = 1; load_b = 0; d_b = 0;
    sclr_c = 0; ce_c = 0; d_c = 0;
    ce_e = 0; up_e = 0; d_e = 0;
    #12;
    chk("rst_q", q_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_tc_up", tc_a, 0);
    up_a = 0; #0.1;
    chk("rst_tc_dn", tc_a, 1);
    chk("rst_ceo_ce0", ceo_a, 0);
    up_a = 1;
    #1 rst_n = 1'b1;

    // wrap up-count through 9 -> 0
    ce_a = 1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("up_q%0d", i), q_a, up_seq[i]);
      chk($sformatf("up_ovf%0d", i), ovf_a, up_ovf[i]);
      chk($sformatf("up_tc%0d", i), tc_a, (up_seq[i] == 9) ? 1 : 0);
    end

    // clear with CE high, then count down from 0
    sclr_a = 1; step(); sclr_a = 0;
    chk("sclr_q", q_a, 0);
    chk("sclr_ovf", ovf_a, 0);
    up_a = 0; #1;
    chk("dn_tc_at0", tc_a, 1);
    chk("dn_ceo_at0", ceo_a, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("dn_q%0d", i), q_a, dn_seq[i]);
      chk($sformatf("dn_tc%0d", i), tc_a, 0);
    end
    chk("dn_ovf", ovf_a, 1);
    up_a = 1; step();
    chk("toggle_q", q_a, 6);

    // load clamp, load with CE low, SCLR over LOAD
    load_a = 1; d_a = 4'd12; step();
    chk("load_clamp", q_a, 9);
    chk("load_keeps_ovf", ovf_a, 1);
    ce_a = 0; d_a = 4'd3; step();
    chk("load_ce0", q_a, 3);
    sclr_a = 1; d_a = 4'd7; step(); sclr_a = 0;
    chk("sclr_load_q", q_a, 0);
    chk("sclr_load_ovf", ovf_a, 0);
    d_a = 4'd12; step(); load_a = 0;
    chk("load_no_ovf_q", q_a, 9);
    chk("load_no_ovf", ovf_a, 0);
    step();
    chk("hold_q", q_a, 9);
    chk("hold_ovf", ovf_a, 0);

    // saturate mode
    load_b = 1; d_b = 4'd8; step(); load_b = 0;
    chk("sat_load", q_b, 8);
    ce_b = 1; up_b = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("sat_up_q%0d", i), q_b, 9);
      chk($sformatf("sat_up_ovf%0d", i), ovf_b, sat_ovf[i]);
    end
    sclr_b = 1; step(); sclr_b = 0;
    chk("sat_sclr_ovf", ovf_b, 0);
    load_b = 1; d_b = 4'd1; step(); load_b = 0;
    up_b = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("sat_dn_q%0d", i), q_b, 0);
      chk($sformatf("sat_dn_ovf%0d", i), ovf_b, sat_ovf[i]);
    end
    ce_b = 0;

    // decade cascade
    sclr_c = 1; step(); sclr_c = 0;
    ce_c = 1;
    for (int i = 1; i <= 100; i++) begin
      step();
      chk($sformatf("casc_lo%0d", i), q_lo, i % 10);
      chk($sformatf("casc_hi%0d", i), q_hi, (i / 10) % 10);
    end
    ce_c = 0;

    // default width: natural wrap at 255
    ce_e = 1; up_e = 0; step();
    chk("w8_dn_wrap", q_e, 255);
    chk("w8_ovf", ovf_e, 1);
    up_e = 1; step();
    chk("w8_up_wrap", q_e, 0);
    ce_e = 0;

    // async reset between edges
    ce_a = 0; load_a = 1; d_a = 4'd9; step();
    load_a = 0; ce_a = 1; up_a = 1; step();
    chk("pre_rst_ovf", ovf_a, 1);
    ce_a = 0; load_a = 1; d_a = 4'd6; step(); load_a = 0;
    chk("pre_rst_q", q_a, 6);
    rst_n = 1'b0; #2;
    chk("async_q", q_a, 0);
    chk("async_ovf", ovf_a, 0);
    #1 rst_n = 1'b1;
    ce_a = 1; step();
    chk("resume_q", q_a, 1);
    chk("resume_ovf", ovf_a, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_updown_mod.md
Name: counter_updown_mod

Overview:
- Parametrised successor to the team's fixed 4-bit up counter.
- Configurable-width up/down counter with programmable maximum value, synchronous clear, parallel load, clock enable, wrap-or-saturate mode, terminal-count output and a sticky overflow flag.
- Used as a generic event/timer counter and as a cascadable prescaler stage: a stage's CEO drives the next stage's CE.

Parameters:
- WIDTH, 8, counter width in bits (1..32).
- MAX_VAL, 2**WIDTH-1, largest count value. Legal range 1..2**WIDTH-1. Count range is 0..MAX_VAL.
- SATURATE, 0. 0 = wrap at the boundaries (MAX_VAL->0 up, 0->MAX_VAL down). 1 = hold at the boundary.

Ports:
- C  input  1  clock, rising edge.
- CLR_N  input  1  asynchronous reset, active-low.
- SCLR  input  1  synchronous clear, active-high.
- CE  input  1  count enable.
- UP_DN  input  1  direction: 1 = up, 0 = down.
- LOAD  input  1  synchronous parallel load.
- D  input  WIDTH  load value.
- Q  output  WIDTH  registered count.
- TC  output  1  terminal count, combinational.
- CEO  output  1  cascade enable, combinational: CE & TC.
- OVF  output  1  sticky boundary-crossing flag, registered.

Behaviour:
- Reset: CLR_N low forces Q=0 and OVF=0 immediately, independent of C. Release is synchronised by the integrator; the block assumes deassertion meets recovery time. While CLR_N is low, TC and CEO follow Q=0.
- Priority on each rising edge of C with CLR_N high: SCLR > LOAD > CE count > hold.
- SCLR: Q<=0, OVF<=0. SCLR takes effect whether or not CE is high.
- LOAD (SCLR=0): Q<=D if D<=MAX_VAL, else Q<=MAX_VAL. LOAD ignores CE and leaves OVF unchanged.
- Count (SCLR=0, LOAD=0, CE=1):
  - Up, Q<MAX_VAL: Q<=Q+1.
  - Up, Q==MAX_VAL: Q<=0 if SATURATE=0, else Q holds. OVF<=1 in both modes.
  - Down, Q>0: Q<=Q-1.
  - Down, Q==0: Q<=MAX_VAL if SATURATE=0, else Q holds. OVF<=1 in both modes.
- Hold (CE=0 and no SCLR/LOAD): Q and OVF unchanged.
- OVF stays at 1 until CLR_N or SCLR clears it. It is set only by CE-driven boundary events, never by LOAD.
- TC = (UP_DN & Q==MAX_VAL) | (~UP_DN & Q==0). TC is independent of CE; CEO gates it with CE.
- Latency: every synchronous operation is visible on Q one cycle after the edge. TC/CEO respond combinationally to Q, UP_DN and CE.
- UP_DN may change on any cycle. The direction sampled at the edge applies to that edge only.
- Arithmetic: unsigned, modulo handled by explicit compare against MAX_VAL, never by natural WIDTH overflow. This keeps non-power-of-two MAX_VAL correct. With MAX_VAL=2**WIDTH-1, behaviour is identical to natural wrap.
- Q never leaves the range 0..MAX_VAL under any input sequence.
- Reset mid-operation: asserting CLR_N mid-count aborts immediately. First edge after release starts from Q=0, OVF=0.

Test Plan:
- WIDTH=4, MAX_VAL=9, SATURATE=0, UP_DN=1, CE=1 for 12 edges from reset -> Q: 1..9,0,1,2. TC=1 only while Q=9. OVF rises on the edge where 9->0 and stays 1.
- Same config, UP_DN=0 from Q=0 -> Q=9 on the next edge, then 8, 7. TC=1 while Q=0 with UP_DN=0. Toggle UP_DN at Q=5 -> next value 6.
- SATURATE=1, MAX_VAL=9, up from Q=8 for 3 edges -> Q=9,9,9, OVF=1. Same check down from Q=1 -> Q=0,0,0.
- LOAD with D=12 (MAX_VAL=9) -> Q=9. LOAD with D=3 while CE=0 -> Q=3. Assert SCLR and LOAD together with D=7 -> Q=0, OVF=0.
- Cascade two instances (MAX_VAL=9), CEO of the low stage driving CE of the high stage, for 100 edges -> high:low reads 0:0 after wrap, high stage increments exactly once per 10 edges.
- Pulse CLR_N low between clock edges while Q=6, OVF=1 -> Q=0 and OVF=0 before the next edge. Counting resumes at 1 after release.
